reorder_buffer: RTL and testbench
=================================

# reorder_buffer

In-order retirement queue of the out-of-order core, and the receiving end of the rename/dispatch ROB enqueue interface. Each dispatched instruction is allocated an entry holding its {done, rd, pd} record, and the allocated index is returned in the same cycle. Completion broadcasts from the CDB mark entries done. The head entry retires in program order toward the RRAT, and a mispredicted control-flow commit raises `jump_commit`, which flushes the front end and the buffer.

## Interface
Parameters:
- `DATA_WIDTH`, 6: physical register index width.
- `ROB_DATA_WIDTH`, 12: enqueue record width, {done, rd[4:0], pd[DATA_WIDTH-1:0]}.
- `ROB_DEPTH`, 16: number of entries; must be a power of two, at least 2.

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: reset, synchronous and active-high.
- `enqueue` in 1: allocate an entry this cycle.
- `rob_data_in` in ROB_DATA_WIDTH: enqueue record; bit[11] = done, [10:6] = rd, [5:0] = pd.
- `rob_idx_out` out $clog2(ROB_DEPTH): index the next enqueue will occupy (current tail).
- `full` out 1: no free entry.
- `empty` out 1: no occupied entry.
- `cdb_valid` in 1: completion broadcast valid.
- `cdb_rob_idx` in $clog2(ROB_DEPTH): entry being completed.
- `cdb_mispredict` in 1: the completing instruction redirected control flow (branch/jal/jalr mispredict).
- `commit_valid` out 1: head entry retires this cycle.
- `commit_rd` out 5: architectural destination of the retiring entry; 0 means no RRAT update.
- `commit_pd` out DATA_WIDTH: physical destination of the retiring entry.
- `commit_rob_idx` out $clog2(ROB_DEPTH): head index.
- `jump_commit` out 1: the retiring entry mispredicted; flush request.

## Operation
State:
- `head` and `tail` pointers, each $clog2(ROB_DEPTH)+1 bits; the MSB is a wrap bit.
- Per-entry `valid`, `done`, `mispredict`, `rd` and `pd`.

Status:
- `empty` = (head == tail).
- `full` = (index bits equal and wrap bits differ).
- `rob_idx_out` = tail[index bits].

Enqueue (`enqueue && !full && !jump_commit`):
- Write the entry at tail: valid = 1, done = rob_data_in[11], mispredict = 0, rd and pd from the record.
- tail += 1 (modulo 2·ROB_DEPTH).
- An enqueue while full is dropped with no state change. Rename must not issue one.

Completion (`cdb_valid`):
- If entry[cdb_rob_idx].valid, set done = 1 and mispredict = cdb_mispredict.
- If the entry is not valid, the broadcast is ignored.

Commit (combinational from head):
- `commit_valid` = !empty && entry[head].done.
- `commit_rd`, `commit_pd` and `commit_rob_idx` are driven from the head entry, and are 0 when commit_valid = 0.
- `jump_commit` = commit_valid && entry[head].mispredict.
- Store and branch entries carry rd = 0 and pd = 0; they retire with commit_rd = 0.
- When commit_valid, at the edge: clear entry[head].valid and head += 1.

Flush (jump_commit = 1 at the edge):
- The retiring entry is consumed.
- All valid and done bits clear, and head = tail = 0.
- Same-cycle enqueue and CDB writes are discarded.

Simultaneous events:
- Enqueue and commit in the same cycle both take effect.
- `full` is evaluated on pre-edge state, so an enqueue while full is rejected even if a commit frees a slot that cycle.

Reset (`rst`):
- head = tail = 0 and all entry bits clear.
- Outputs: empty = 1, full = 0, rob_idx_out = 0, commit_valid = 0, commit_rd = 0, commit_pd = 0, commit_rob_idx = 0, jump_commit = 0.
- `rst` takes priority over every other input, including mid-flush.

## Timing
- `rob_idx_out`, `full` and `empty` reflect registered state only; they never depend combinationally on same-cycle inputs.
- Enqueue to visible: the entry is visible to commit from the cycle after the enqueue edge.
- An entry enqueued with done = 1 can retire one cycle after enqueue.
- CDB to commit: done is registered, so the head commits at the earliest one cycle after its `cdb_valid`.
- Throughput: at most one commit and one enqueue per cycle.
- `jump_commit` is a single-cycle pulse. From the following cycle: empty = 1 and rob_idx_out = 0.

## Structure
- `rob_entry_t` = {valid, done, mispredict, rd[4:0], pd[DATA_WIDTH-1:0]} is defined in `rv32i_types`, next to the RS data structs.
- The bit positions of the enqueue record are package constants shared with rename/dispatch.
- Single module, no sub-module: the entry array plus pointer logic fits in roughly 150–250 lines.

## Test plan
- Reset, then enqueue {0, rd = 5, pd = 33}:
  - Pre-edge, rob_idx_out = 0.
  - Next cycle, rob_idx_out = 1 and empty = 0.
  - Then CDB idx 0: one cycle later, commit_valid = 1 with commit_rd = 5 and commit_pd = 33; the following cycle, empty = 1.
- Out-of-order completion:
  - Enqueue idx 0, 1, 2; CDB completes 2, then 1; commit_valid stays 0.
  - CDB completes 0: idx 0, 1, 2 then retire on three consecutive cycles.
- Fill and wrap:
  - 16 enqueues make full = 1; a 17th enqueue leaves tail unchanged.
  - Complete and commit idx 0, then enqueue: the new entry takes idx 0, with wrap bit toggled and full = 1 again.
- Mispredict flush:
  - Enqueue 4 entries; CDB idx 0 with mispredict = 1.
  - Next cycle, jump_commit = 1 and commit_rob_idx = 0.
  - The cycle after, empty = 1, rob_idx_out = 0, and a late CDB for idx 2 is ignored.
- Enqueue and commit in the same cycle while 15 entries are occupied: count stays 15 and full = 0.
- Store entry {1, 0, 0}: it commits one cycle after enqueue with commit_rd = 0; assert `rst` mid-stream and check all outputs return to reset values.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared core types: ROB entry record and the bit layout of the enqueue
// record exchanged between rename/dispatch and the reorder buffer.
package rv32i_types;

   localparam int PHYS_REG_W = 6;
   localparam int ARCH_REG_W = 5;

   // Enqueue record layout: {done, rd[4:0], pd[5:0]}
   localparam int ROB_REC_DONE_BIT = 11;
   localparam int ROB_REC_RD_MSB   = 10;
   localparam int ROB_REC_RD_LSB   = 6;
   localparam int ROB_REC_PD_MSB   = 5;
   localparam int ROB_REC_PD_LSB   = 0;

   typedef struct packed {
      logic                  valid;
      logic                  done;
      logic                  mispredict;
      logic [ARCH_REG_W-1:0] rd;
      logic [PHYS_REG_W-1:0] pd;
   } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement queue. Dispatch allocates entries at the tail, CDB
// broadcasts mark them done, and the head retires toward the RRAT. A
// mispredicted head raises jump_commit and flushes the whole buffer.
module reorder_buffer
   import rv32i_types::*;
#(
   parameter int DATA_WIDTH     = 6,
   parameter int ROB_DATA_WIDTH = 12,
   parameter int ROB_DEPTH      = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enqueue,
   input  logic [ROB_DATA_WIDTH-1:0]    rob_data_in,
   output logic [$clog2(ROB_DEPTH)-1:0] rob_idx_out,
   output logic                         full,
   output logic                         empty,
   input  logic                         cdb_valid,
   input  logic [$clog2(ROB_DEPTH)-1:0] cdb_rob_idx,
   input  logic                         cdb_mispredict,
   output logic                         commit_valid,
   output logic [4:0]                   commit_rd,
   output logic [DATA_WIDTH-1:0]        commit_pd,
   output logic [$clog2(ROB_DEPTH)-1:0] commit_rob_idx,
   output logic                         jump_commit
);

   localparam int IDX_W = $clog2(ROB_DEPTH);
   localparam logic [IDX_W:0] PTR_ONE = {{IDX_W{1'b0}}, 1'b1};

   // Pointers carry an extra wrap bit so full and empty are distinguishable.
   logic [IDX_W:0] head;
   logic [IDX_W:0] tail;
   logic [IDX_W-1:0] head_idx;
   logic [IDX_W-1:0] tail_idx;

   // Control bits live in flat vectors; payload lives in plain arrays.
   logic [ROB_DEPTH-1:0] valid_q;
   logic [ROB_DEPTH-1:0] done_q;
   logic [ROB_DEPTH-1:0] mispredict_q;
   logic [4:0]            rd_q [ROB_DEPTH];
   logic [DATA_WIDTH-1:0] pd_q [ROB_DEPTH];

   rob_entry_t head_entry;
   logic       do_enqueue;
   logic       cdb_hit;

   assign head_idx = head[IDX_W-1:0];
   assign tail_idx = tail[IDX_W-1:0];

   assign empty       = (head == tail);
   assign full        = (head_idx == tail_idx) && (head[IDX_W] != tail[IDX_W]);
   assign rob_idx_out = tail_idx;

   // full is judged on pre-edge state, so a same-cycle commit never admits a
   // blocked enqueue; a flush cycle also swallows the enqueue.
   assign do_enqueue = enqueue && !full && !jump_commit;
   assign cdb_hit    = cdb_valid && valid_q[cdb_rob_idx];

   // Gather the head entry into one record for the commit logic.
   always_comb begin
      head_entry            = '0;
      head_entry.valid      = valid_q[head_idx];
      head_entry.done       = done_q[head_idx];
      head_entry.mispredict = mispredict_q[head_idx];
      head_entry.rd         = rd_q[head_idx];
      head_entry.pd         = pd_q[head_idx];
   end

   assign commit_valid   = !empty && head_entry.valid && head_entry.done;
   assign jump_commit    = commit_valid && head_entry.mispredict;
   assign commit_rd      = commit_valid ? head_entry.rd : '0;
   assign commit_pd      = commit_valid ? head_entry.pd : '0;
   assign commit_rob_idx = commit_valid ? head_idx : '0;

   // Pointer and per-entry status update: reset, flush, then commit/enqueue/CDB.
   always_ff @(posedge clk) begin
      if (rst) begin
         head         <= '0;
         tail         <= '0;
         valid_q      <= '0;
         done_q       <= '0;
         mispredict_q <= '0;
      end else if (jump_commit) begin
         head         <= '0;
         tail         <= '0;
         valid_q      <= '0;
         done_q       <= '0;
         mispredict_q <= '0;
      end else begin
         // A CDB to the head in its retiring cycle is harmless: the entry is
         // being released anyway. A CDB never targets the slot being
         // enqueued because that slot is invalid before the edge.
         if (cdb_hit) begin
            done_q[cdb_rob_idx]       <= 1'b1;
            mispredict_q[cdb_rob_idx] <= cdb_mispredict;
         end
         if (commit_valid) begin
            valid_q[head_idx] <= 1'b0;
            head              <= head + PTR_ONE;
         end
         if (do_enqueue) begin
            valid_q[tail_idx]      <= 1'b1;
            done_q[tail_idx]       <= rob_data_in[ROB_REC_DONE_BIT];
            mispredict_q[tail_idx] <= 1'b0;
            tail                   <= tail + PTR_ONE;
         end
      end
   end

   // Payload write at the tail; only meaningful while the entry is valid.
   always_ff @(posedge clk) begin
      if (do_enqueue) begin
         rd_q[tail_idx] <= rob_data_in[ROB_REC_RD_MSB:ROB_REC_RD_LSB];
         pd_q[tail_idx] <= rob_data_in[ROB_REC_PD_MSB:ROB_REC_PD_LSB];
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: a count/head queue model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_reorder_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        enqueue;
   logic [11:0] rob_data_in;
   logic [3:0]  rob_idx_out;
   logic        full;
   logic        empty;
   logic        cdb_valid;
   logic [3:0]  cdb_rob_idx;
   logic        cdb_mispredict;
   logic        commit_valid;
   logic [4:0]  commit_rd;
   logic [5:0]  commit_pd;
   logic [3:0]  commit_rob_idx;
   logic        jump_commit;

   int errors = 0;
   int checks = 0;

   reorder_buffer #(.DATA_WIDTH(6), .ROB_DATA_WIDTH(12), .ROB_DEPTH(16)) dut (
      .clk(clk), .rst(rst), .enqueue(enqueue), .rob_data_in(rob_data_in),
      .rob_idx_out(rob_idx_out), .full(full), .empty(empty),
      .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx),
      .cdb_mispredict(cdb_mispredict), .commit_valid(commit_valid),
      .commit_rd(commit_rd), .commit_pd(commit_pd),
      .commit_rob_idx(commit_rob_idx), .jump_commit(jump_commit)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: program-order queue ----------------
   // Occupancy is a count starting at a head slot; slots are 0..15.
   bit started = 0;
   int m_head, m_cnt;
   bit m_valid[16];
   bit m_done[16];
   bit m_mis[16];
   int m_rd[16];
   int m_pd[16];

   function automatic bit m_cv();
      return (m_cnt > 0) && m_done[m_head];
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         started = 1;
         m_head = 0;
         m_cnt = 0;
         for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_done[i] = 0; m_mis[i] = 0;
         end
      end else if (started) begin
         bit cv, jmp, was_full;
         int h0, c0, slot;
         cv = m_cv();
         jmp = cv && m_mis[m_head];
         was_full = (m_cnt == 16);
         h0 = m_head;
         c0 = m_cnt;
         if (jmp) begin
            m_head = 0;
            m_cnt = 0;
            for (int i = 0; i < 16; i++) begin
               m_valid[i] = 0; m_done[i] = 0; m_mis[i] = 0;
            end
         end else begin
            if (cdb_valid && m_valid[cdb_rob_idx]) begin
               m_done[cdb_rob_idx] = 1;
               m_mis[cdb_rob_idx] = cdb_mispredict;
            end
            if (cv) begin
               m_valid[h0] = 0;
               m_head = (h0 + 1) % 16;
               m_cnt--;
            end
            if (enqueue && !was_full) begin
               slot = (h0 + c0) % 16;
               m_valid[slot] = 1;
               m_done[slot] = rob_data_in[11];
               m_mis[slot] = 0;
               m_rd[slot] = int'(rob_data_in[10:6]);
               m_pd[slot] = int'(rob_data_in[5:0]);
               m_cnt++;
            end
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (started) begin
         bit cv;
         cv = m_cv();
         check("m_empty", 32'(empty), 32'(m_cnt == 0));
         check("m_full", 32'(full), 32'(m_cnt == 16));
         check("m_rob_idx_out", 32'(rob_idx_out), 32'((m_head + m_cnt) % 16));
         check("m_commit_valid", 32'(commit_valid), 32'(cv));
         check("m_commit_rd", 32'(commit_rd), cv ? 32'(m_rd[m_head]) : 32'd0);
         check("m_commit_pd", 32'(commit_pd), cv ? 32'(m_pd[m_head]) : 32'd0);
         check("m_commit_rob_idx", 32'(commit_rob_idx), cv ? 32'(m_head) : 32'd0);
         check("m_jump_commit", 32'(jump_commit), 32'(cv && m_mis[m_head]));
      end
   end

   // ---------------- stimulus ----------------
   function automatic logic [11:0] rec(input logic d, input logic [4:0] rd, input logic [5:0] pd);
      return {d, rd, pd};
   endfunction

   // Drive one cycle of inputs; returns 1 time unit after the capturing edge.
   task automatic tick(input logic en, input logic [11:0] data, input logic cv,
                       input logic [3:0] ci, input logic cm);
      enqueue = en;
      rob_data_in = data;
      cdb_valid = cv;
      cdb_rob_idx = ci;
      cdb_mispredict = cm;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      tick(1'b0, 12'd0, 1'b0, 4'd0, 1'b0);
   endtask

   task automatic cdb(input logic [3:0] idx, input logic mis);
      tick(1'b0, 12'd0, 1'b1, idx, mis);
   endtask

   task automatic enq(input logic [11:0] data);
      tick(1'b1, data, 1'b0, 4'd0, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      rst = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_empty"}, 32'(empty), 32'd1);
      check({tag, "_full"}, 32'(full), 32'd0);
      check({tag, "_rob_idx_out"}, 32'(rob_idx_out), 32'd0);
      check({tag, "_commit_valid"}, 32'(commit_valid), 32'd0);
      check({tag, "_commit_rd"}, 32'(commit_rd), 32'd0);
      check({tag, "_commit_pd"}, 32'(commit_pd), 32'd0);
      check({tag, "_commit_rob_idx"}, 32'(commit_rob_idx), 32'd0);
      check({tag, "_jump_commit"}, 32'(jump_commit), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      enqueue = 0; rob_data_in = 0; cdb_valid = 0; cdb_rob_idx = 0; cdb_mispredict = 0;
      @(posedge clk); #1;
      idle();
      check_reset_outputs("reset");
      rst = 1'b0;

      // Single entry: enqueue, complete, retire.
      check("t1_idx_pre", 32'(rob_idx_out), 32'd0);
      enq(rec(1'b0, 5'd5, 6'd33));
      check("t1_idx_post", 32'(rob_idx_out), 32'd1);
      check("t1_empty", 32'(empty), 32'd0);
      check("t1_cv_wait", 32'(commit_valid), 32'd0);
      cdb(4'd0, 1'b0);
      check("t1_cv", 32'(commit_valid), 32'd1);
      check("t1_rd", 32'(commit_rd), 32'd5);
      check("t1_pd", 32'(commit_pd), 32'd33);
      check("t1_ridx", 32'(commit_rob_idx), 32'd0);
      idle();
      check("t1_empty_after", 32'(empty), 32'd1);

      // Out-of-order completion, in-order retirement.
      do_reset();
      enq(rec(1'b0, 5'd1, 6'd10));
      enq(rec(1'b0, 5'd2, 6'd11));
      enq(rec(1'b0, 5'd3, 6'd12));
      cdb(4'd2, 1'b0);
      check("t2_cv_a", 32'(commit_valid), 32'd0);
      cdb(4'd1, 1'b0);
      check("t2_cv_b", 32'(commit_valid), 32'd0);
      cdb(4'd0, 1'b0);
      check("t2_c0_idx", 32'(commit_rob_idx), 32'd0);
      check("t2_c0_rd", 32'(commit_rd), 32'd1);
      idle();
      check("t2_c1_idx", 32'(commit_rob_idx), 32'd1);
      check("t2_c1_pd", 32'(commit_pd), 32'd11);
      idle();
      check("t2_c2_idx", 32'(commit_rob_idx), 32'd2);
      check("t2_c2_rd", 32'(commit_rd), 32'd3);
      idle();
      check("t2_empty", 32'(empty), 32'd1);

      // Fill, reject overflow, free one slot and wrap.
      do_reset();
      for (int i = 0; i < 16; i++) enq(rec(1'b0, 5'(i + 1), 6'(i + 40)));
      check("t3_full", 32'(full), 32'd1);
      check("t3_idx_full", 32'(rob_idx_out), 32'd0);
      enq(rec(1'b1, 5'd31, 6'd63));
      check("t3_full_drop", 32'(full), 32'd1);
      check("t3_idx_drop", 32'(rob_idx_out), 32'd0);
      cdb(4'd0, 1'b0);
      check("t3_cv", 32'(commit_valid), 32'd1);
      check("t3_rd", 32'(commit_rd), 32'd1);
      idle();
      check("t3_full_freed", 32'(full), 32'd0);
      check("t3_idx_freed", 32'(rob_idx_out), 32'd0);
      enq(rec(1'b0, 5'd9, 6'd9));
      check("t3_full_wrap", 32'(full), 32'd1);
      check("t3_idx_wrap", 32'(rob_idx_out), 32'd1);

      // Mispredict flush with same-cycle enqueue/CDB and a late CDB.
      do_reset();
      for (int i = 0; i < 4; i++) enq(rec(1'b0, 5'(i + 1), 6'(i + 20)));
      cdb(4'd0, 1'b1);
      check("t4_jump", 32'(jump_commit), 32'd1);
      check("t4_ridx", 32'(commit_rob_idx), 32'd0);
      check("t4_rd", 32'(commit_rd), 32'd1);
      tick(1'b1, rec(1'b1, 5'd7, 6'd7), 1'b1, 4'd1, 1'b0);
      check("t4_empty", 32'(empty), 32'd1);
      check("t4_idx", 32'(rob_idx_out), 32'd0);
      check("t4_jump_pulse", 32'(jump_commit), 32'd0);
      cdb(4'd2, 1'b0);
      check("t4_late_cdb_cv", 32'(commit_valid), 32'd0);
      check("t4_late_cdb_empty", 32'(empty), 32'd1);

      // Enqueue and commit together with 15 occupied.
      do_reset();
      for (int i = 0; i < 15; i++) enq(rec(1'b0, 5'(i), 6'(i)));
      cdb(4'd0, 1'b0);
      check("t5_cv", 32'(commit_valid), 32'd1);
      check("t5_full_pre", 32'(full), 32'd0);
      enq(rec(1'b0, 5'd30, 6'd50));
      check("t5_full", 32'(full), 32'd0);
      check("t5_idx", 32'(rob_idx_out), 32'd0);
      check("t5_empty", 32'(empty), 32'd0);

      // Store entry retires immediately; reset mid-stream.
      do_reset();
      enq(rec(1'b1, 5'd0, 6'd0));
      check("t6_cv", 32'(commit_valid), 32'd1);
      check("t6_rd", 32'(commit_rd), 32'd0);
      check("t6_pd", 32'(commit_pd), 32'd0);
      enq(rec(1'b1, 5'd7, 6'd9));
      check("t6_cv2", 32'(commit_valid), 32'd1);
      check("t6_rd2", 32'(commit_rd), 32'd7);
      rst = 1'b1;
      tick(1'b1, rec(1'b0, 5'd3, 6'd3), 1'b1, 4'd1, 1'b1);
      check_reset_outputs("t6_rst");
      rst = 1'b0;
      idle();
      check_reset_outputs("t6_after");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
